// File: rtl/number_pkg.sv
// Shared definitions for the BCD/binary number paths: FSM state type and BCD digit width.
package number_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal accumulation step: acc*10 + digit, with illegal-digit detect and overflow saturation.
module bcd_mac_step
  import number_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [BCD_W-1:0] digit,
  output logic [WIDTH-1:0] next_acc,
  output logic             err
);

  logic [WIDTH+3:0] ext;
  logic [WIDTH+3:0] times10;
  logic [WIDTH+3:0] sum;
  logic [BCD_W-1:0] addend;
  logic             illegal;
  logic             overflow;

  // Four guard bits hold acc*10+15 exactly, so any set guard bit means the result no longer fits.
  always_comb begin
    ext      = {4'b0000, acc};
    times10  = (ext << 3) + (ext << 1);
    illegal  = (digit > 4'd9);
    addend   = illegal ? 4'd0 : digit;
    sum      = times10 + {{WIDTH{1'b0}}, addend};
    overflow = |sum[WIDTH+3:WIDTH];
    next_acc = overflow ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    err      = illegal | overflow;
  end

endmodule

// File: rtl/number_encoder.sv
// Packed BCD to binary converter: one digit per cycle, most significant first, sticky error flag.
module number_encoder
  import number_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [BCD_W*DIGITS-1:0]   i_bcd,
  output logic                      o_busy,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_err
);

  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  state_t                    state;
  logic [BCD_W*DIGITS-1:0]   shreg;
  logic [WIDTH-1:0]          acc;
  logic [WIDTH-1:0]          step_acc;
  logic [CNT_W-1:0]          cnt;
  logic                      flag;
  logic                      step_err;
  logic                      flag_next;

  assign flag_next = flag | step_err;

  // The latched digits shift left each cycle so the current digit is always the top nibble.
  bcd_mac_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .digit   (shreg[BCD_W*DIGITS-1 -: BCD_W]),
    .next_acc(step_acc),
    .err     (step_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      flag    <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            shreg  <= i_bcd;
            acc    <= '0;
            cnt    <= '0;
            flag   <= 1'b0;
            o_busy <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          acc   <= step_acc;
          flag  <= flag_next;
          shreg <= shreg << BCD_W;
          cnt   <= cnt + 1'b1;
          // Results are registered on the last digit so they appear together with the DONE pulse.
          if (cnt == LAST) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_data  <= flag_next ? '0 : step_acc;
            o_err   <= flag_next;
          end
        end
        DONE: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_number_encoder.sv
// Scoreboard bench for number_encoder: a cycle model predicts acceptance, latency and results.
module tb_number_encoder;

  localparam int DIGITS = 8;
  localparam int WIDTH  = 18;
  localparam longint MAXV = (longint'(1) << WIDTH) - 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               due;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_start = 1'b0;
  logic [4*DIGITS-1:0] i_bcd = '0;
  logic                o_busy;
  logic                o_valid;
  logic [WIDTH-1:0]    o_data;
  logic                o_err;

  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               model_cnt = 0;
  exp_t             sb[$];
  logic [WIDTH-1:0] last_data = '0;
  logic             last_err = 1'b0;

  number_encoder #(
    .DIGITS(DIGITS),
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_bcd  (i_bcd),
    .o_busy (o_busy),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Expected result from the decimal value of the digits, independent of the stepwise datapath.
  function automatic void ref_value(input logic [4*DIGITS-1:0] bcd,
                                    output logic [WIDTH-1:0] d, output logic e);
    longint     v = 0;
    logic       illegal = 1'b0;
    logic [3:0] dig;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig = bcd[4*k +: 4];
      if (dig > 4'd9) illegal = 1'b1;
      else v = v * 10 + longint'(dig);
    end
    e = illegal || (v > MAXV);
    d = e ? '0 : WIDTH'(v);
  endfunction

  function automatic logic [4*DIGITS-1:0] bin2bcd(input int value);
    logic [4*DIGITS-1:0] r = '0;
    int                  v = value;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Cycle model: inputs are sampled at the edge, outputs checked 1 time unit later.
  always @(posedge clk) begin
    logic [WIDTH-1:0] d;
    logic             e;
    logic             exp_valid;
    if (rst) begin
      model_cnt = 0;
      sb.delete();
      last_data = '0;
      last_err  = 1'b0;
    end else if (model_cnt == 0 && i_start) begin
      ref_value(i_bcd, d, e);
      sb.push_back('{data: d, err: e, due: cyc + DIGITS + 1});
      model_cnt = DIGITS + 1;
    end else if (model_cnt > 0) begin
      model_cnt--;
    end
    cyc++;
    #1;
    exp_valid = (sb.size() > 0) && (sb[0].due == cyc);
    checkOutput("busy", 32'(o_busy), 32'(model_cnt > 0));
    checkOutput("valid", 32'(o_valid), 32'(exp_valid));
    if (exp_valid) begin
      last_data = sb[0].data;
      last_err  = sb[0].err;
      void'(sb.pop_front());
    end
    checkOutput("data", 32'(o_data), 32'(last_data));
    checkOutput("err", 32'(o_err), 32'(last_err));
  end

  task automatic waitIdle();
    int guard = 0;
    while ((model_cnt != 0) && (guard < 100)) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("idle_timeout", 32'(guard), 32'(0));
  endtask

  task automatic applyStimulus(input logic [4*DIGITS-1:0] bcd);
    waitIdle();
    @(negedge clk);
    i_bcd   = bcd;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_bcd   = $urandom();
  endtask

  initial begin
    int guard;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(o_busy), 32'(0));
    checkOutput("reset_valid", 32'(o_valid), 32'(0));
    checkOutput("reset_data", 32'(o_data), 32'(0));
    checkOutput("reset_err", 32'(o_err), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(32'h00012345);
    applyStimulus(32'h00262143);
    applyStimulus(32'h00262144);
    applyStimulus(32'h000A0001);
    applyStimulus(32'h00000000);
    applyStimulus(32'h99999999);

    // Start held high: a result every DIGITS+2 cycles; the mid-conversion change applies next time.
    waitIdle();
    @(negedge clk);
    i_bcd   = 32'h00000007;
    i_start = 1'b1;
    repeat (5) @(negedge clk);
    i_bcd = 32'h00000009;
    repeat (26) @(negedge clk);
    i_start = 1'b0;

    // Reset four cycles into a conversion aborts it; the next request converts normally.
    waitIdle();
    applyStimulus(32'h00054321);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort_data", 32'(o_data), 32'(0));
    applyStimulus(32'h00000042);

    for (int n = 0; n < 20; n++) begin
      int v;
      v = int'($urandom_range(262143, 0));
      applyStimulus(bin2bcd(v));
    end

    guard = 0;
    while ((sb.size() != 0) && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 32'(sb.size()), 32'(0));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/number_encoder.md
NUMBER_ENCODER -- requirements
Module: number_encoder

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of packed BCD digits accepted.
REQ-002 SHALL have parameter WIDTH, default 18: binary result width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1: request to convert i_bcd.
REQ-006 SHALL have port i_bcd, input, 4*DIGITS: packed BCD, digit k at bits [4k+3:4k], digit 0 least significant.
REQ-007 SHALL have port o_busy, output, 1: conversion in progress.
REQ-008 SHALL have port o_valid, output, 1: one-cycle pulse marking a new result.
REQ-009 SHALL have port o_data, output, WIDTH: binary value of last conversion.
REQ-010 SHALL have port o_err, output, 1: last conversion had an illegal digit or overflowed.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, DONE.
- IDLE->CONV on i_start=1.
- CONV->DONE after DIGITS digit cycles.
- DONE->IDLE unconditionally.
REQ-012 In IDLE with i_start=1 at cycle T, SHALL latch i_bcd, clear accumulator, digit counter and error flag.
REQ-013 In CONV cycles T+1..T+DIGITS, SHALL process one digit per cycle, most significant first: acc <= acc*10 + digit.
REQ-014 SHALL compute acc*10 as (acc<<3)+(acc<<1) in WIDTH+4 bits; no divider, no multiplier.
REQ-015 Any digit value 10..15 SHALL set the sticky error flag; that digit contributes 0.
REQ-016 If acc*10+digit exceeds 2**WIDTH-1 at any step, SHALL set the sticky error flag and hold acc at 2**WIDTH-1 for the remaining steps.
REQ-017 In DONE (cycle T+DIGITS+1), SHALL drive o_valid=1 for exactly one cycle.
- Same cycle: o_data=acc and o_err=flag when flag=0.
- Same cycle: o_data=0 and o_err=1 when flag=1.
REQ-018 o_data and o_err SHALL hold their values until the next DONE cycle.
REQ-019 o_busy SHALL be 1 in CONV and DONE and 0 in IDLE; total latency T to o_valid is DIGITS+1 cycles.
REQ-020 i_start while o_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 i_start in the cycle after DONE (IDLE) SHALL be accepted; back-to-back throughput is one result per DIGITS+2 cycles.
REQ-022 Changes on i_bcd after acceptance SHALL NOT affect the result in progress.
REQ-023 Leading zero digits SHALL be legal; all-zero input SHALL yield o_data=0, o_err=0.

Reset
REQ-024 With rst=1 at a clock edge, SHALL set state=IDLE, o_busy=0, o_valid=0, o_data=0, o_err=0, and clear accumulator, counter and flag.
REQ-025 Reset asserted mid-conversion SHALL abort it with no o_valid pulse; the first i_start after rst deasserts is accepted normally.

Structure
REQ-026 SHALL define the FSM state typedef and a BCD digit-width constant (4) in shared package number_pkg, also usable by the existing binary-to-BCD display path.
REQ-027 SHALL place the per-digit step (acc*10+digit, illegal-digit detect, overflow saturate) in combinational sub-module bcd_mac_step; the FSM, counter and registers remain in number_encoder.

Verification
REQ-028 Bench SHALL cover i_bcd=32'h00012345, i_start pulse at T -> o_valid only at T+9, o_data=12345, o_err=0, o_busy high T+1..T+9.
REQ-029 Bench SHALL cover i_bcd=32'h00262143 -> o_data=262143, o_err=0; i_bcd=32'h00262144 -> o_data=0, o_err=1.
REQ-030 Bench SHALL cover i_bcd=32'h000A0001 (illegal digit) -> o_data=0, o_err=1, latency still 9.
REQ-031 Bench SHALL cover i_start held high continuously with i_bcd=32'h00000007 -> o_valid every 10 cycles, o_data=7; i_bcd changed to 32'h00000009 mid-conversion takes effect only in the next conversion.
REQ-032 Bench SHALL cover rst=1 at T+4 of a conversion -> no o_valid, all outputs 0; a new i_start with 32'h00000042 -> o_data=42.
REQ-033 Bench SHALL cover a round trip: random values 0..262143 through the existing binary-to-BCD path and back -> o_data equals the original, o_err=0.
